// File: rtl/a2d_pkg.sv
// Shared types and sizes for the A2D scan sequencer.
package a2d_pkg;
  localparam int NUM_CH = 8;
  localparam int RES_W  = 12;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PTR_W  = CH_W + 1;

  typedef enum logic [2:0] {IDLE, PICK, START, CONV, GAP} state_t;
  typedef enum logic {SCAN, HOST} src_t;

  // The ADC128S path returns complemented data; optionally undo it.
  function automatic logic [RES_W-1:0] fix_res(input logic [RES_W-1:0] r, input logic inv);
    return inv ? ~r : r;
  endfunction
endpackage

// File: rtl/a2d_next_ch.sv
// Lowest set bit of mask at or above ptr; ptr may equal NUM_CH (nothing left).
module a2d_next_ch
  import a2d_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [PTR_W-1:0]  ptr,
  output logic [CH_W-1:0]   ch,
  output logic              found
);
  always_comb begin
    ch    = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (PTR_W'(i) >= ptr)) begin
        ch    = CH_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin ADC scan sequencer with host single-shot requests and a
// per-channel result register file.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int SCAN_GAP    = 1024,
  parameter int CNV_TIMEOUT = 4096,
  parameter bit INVERT_RES  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic                    strt_cnv,
  output logic [CH_W-1:0]         chnnl,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  input  logic                    req,
  input  logic [CH_W-1:0]         req_chnnl,
  output logic                    req_ack,
  output logic                    req_done,
  output logic [RES_W-1:0]        req_res,
  output logic [NUM_CH*RES_W-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_vld,
  output logic                    scan_done,
  output logic                    cnv_err,
  output logic                    busy
);
  localparam int TO_W  = (CNV_TIMEOUT > 2) ? $clog2(CNV_TIMEOUT) : 1;
  localparam int GAP_W = (SCAN_GAP > 2) ? $clog2(SCAN_GAP) : 1;
  // Decision is made one cycle early so cnv_err lands as the counter hits CNV_TIMEOUT-1.
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(CNV_TIMEOUT - 2);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(SCAN_GAP - 1);
  localparam state_t           AFTER_SCAN = (SCAN_GAP == 0) ? IDLE : GAP;

  state_t                        state, nxt;
  src_t                          src;
  logic [PTR_W-1:0]              ptr, ptr_inc, nc_ptr;
  logic [CH_W-1:0]               nc_ch;
  logic                          nc_found;
  logic                          scan_act, gap_pend;
  logic [GAP_W-1:0]              gap_cnt;
  logic [TO_W-1:0]               to_cnt;
  logic [NUM_CH-1:0][RES_W-1:0]  ch_reg;
  logic                          cmplt_ok, tmo, conv_end;

  assign ch_data = ch_reg;
  assign ptr_inc = PTR_W'(chnnl) + PTR_W'(1);
  // PICK searches from the scan pointer; at the end of a scan slot the same
  // search from target+1 tells whether this was the last enabled channel.
  assign nc_ptr  = (state == CONV && src == SCAN) ? ptr_inc : ptr;

  a2d_next_ch u_next_ch (
    .mask  (ch_mask),
    .ptr   (nc_ptr),
    .ch    (nc_ch),
    .found (nc_found)
  );

  // to_cnt is 0 only on the first CONV cycle, which doubles as the blanking window.
  assign cmplt_ok = (state == CONV) && (to_cnt != '0) && cnv_cmplt;
  assign tmo      = (state == CONV) && !cmplt_ok && (to_cnt == TO_LAST);
  assign conv_end = cmplt_ok || tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req || (en && |ch_mask)) nxt = PICK;
      PICK: begin
        if (req || nc_found) nxt = START;
        else if (scan_act)   nxt = AFTER_SCAN;
        else                 nxt = IDLE;
      end
      START: nxt = CONV;
      CONV: begin
        if (conv_end) begin
          if (src == SCAN && !nc_found) nxt = AFTER_SCAN;
          else if (req || scan_act)     nxt = PICK;
          else if (gap_pend)            nxt = GAP;
          else                          nxt = IDLE;
        end
      end
      GAP: begin
        if (req)                       nxt = PICK;
        else if (gap_cnt == GAP_LAST)  nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    strt_cnv = 1'b0;
    req_ack  = 1'b0;
    busy     = 1'b1;
    case (state)
      START: begin
        strt_cnv = 1'b1;
        req_ack  = (src == HOST);
      end
      IDLE, GAP: busy = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src       <= SCAN;
      chnnl     <= '0;
      ptr       <= '0;
      scan_act  <= 1'b0;
      gap_pend  <= 1'b0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      ch_reg    <= '0;
      ch_vld    <= '0;
      req_res   <= '0;
      req_done  <= 1'b0;
      scan_done <= 1'b0;
      cnv_err   <= 1'b0;
    end else begin
      req_done  <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        PICK: begin
          if (req) begin
            chnnl <= req_chnnl;
            src   <= HOST;
          end else if (nc_found) begin
            chnnl    <= nc_ch;
            src      <= SCAN;
            scan_act <= 1'b1;
          end else if (scan_act) begin
            // Mask shrank under the pointer: the scan is over.
            scan_done <= 1'b1;
            scan_act  <= 1'b0;
            ptr       <= '0;
            gap_pend  <= (SCAN_GAP != 0);
            gap_cnt   <= '0;
          end
        end
        START: to_cnt <= '0;
        CONV: begin
          to_cnt <= to_cnt + 1'b1;
          if (tmo) cnv_err <= 1'b1;
          if (cmplt_ok) begin
            if (src == HOST) begin
              req_res  <= fix_res(res, INVERT_RES);
              req_done <= 1'b1;
            end else begin
              ch_reg[chnnl] <= fix_res(res, INVERT_RES);
              ch_vld[chnnl] <= 1'b1;
            end
          end
          if (conv_end && src == SCAN) begin
            if (nc_found) begin
              ptr <= ptr_inc;
            end else begin
              scan_done <= 1'b1;
              scan_act  <= 1'b0;
              ptr       <= '0;
              gap_pend  <= (SCAN_GAP != 0);
              gap_cnt   <= '0;
            end
          end
        end
        GAP: begin
          // A pending host request freezes the gap count.
          if (!req) begin
            if (gap_cnt == GAP_LAST) gap_pend <= 1'b0;
            else                     gap_cnt  <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Scoreboard bench for a2d_scan_ctrl: ADC model, expected channel/result queues.
module tb_a2d_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, req = 1'b0, cnv_cmplt = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [11:0] res = '0;
  logic [2:0]  req_chnnl = '0;

  logic        strt_cnv, req_ack, req_done, scan_done, cnv_err, busy;
  logic [2:0]  chnnl;
  logic [11:0] req_res;
  logic [95:0] ch_data;
  logic [7:0]  ch_vld;

  logic        strt_cnv0, req_ack0, req_done0, scan_done0, cnv_err0, busy0;
  logic [2:0]  chnnl0;
  logic [11:0] req_res0;
  logic [95:0] ch_data0;
  logic [7:0]  ch_vld0;

  int nchk = 0, nerr = 0, cyc = 0;
  logic [2:0]  exp_chq[$];
  logic [11:0] exp_resq[$];

  logic [11:0] adc_raw[8];
  bit          hold0 = 1'b0;
  int          cd = 0;
  logic [2:0]  mch = '0;

  a2d_scan_ctrl #(.SCAN_GAP(16), .CNV_TIMEOUT(64), .INVERT_RES(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .strt_cnv(strt_cnv),
    .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res), .req(req), .req_chnnl(req_chnnl),
    .req_ack(req_ack), .req_done(req_done), .req_res(req_res), .ch_data(ch_data),
    .ch_vld(ch_vld), .scan_done(scan_done), .cnv_err(cnv_err), .busy(busy)
  );

  a2d_scan_ctrl #(.SCAN_GAP(16), .CNV_TIMEOUT(64), .INVERT_RES(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .strt_cnv(strt_cnv0),
    .chnnl(chnnl0), .cnv_cmplt(cnv_cmplt), .res(res), .req(req), .req_chnnl(req_chnnl),
    .req_ack(req_ack0), .req_done(req_done0), .req_res(req_res0), .ch_data(ch_data0),
    .ch_vld(ch_vld0), .scan_done(scan_done0), .cnv_err(cnv_err0), .busy(busy0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: completion 4 cycles after strt_cnv, level cleared by strt_cnv.
  always @(posedge clk) begin
    if (strt_cnv) begin
      cnv_cmplt <= 1'b0;
      mch       <= chnnl;
      cd        <= 4;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !(hold0 && mch == 3'd0)) begin
        cnv_cmplt <= 1'b1;
        res       <= adc_raw[mch];
      end
    end
  end

  // Scoreboard: every strt_cnv and every req_done consumes one expectation.
  always @(negedge clk) begin
    logic [2:0]  ec;
    logic [11:0] er;
    if (rst_n && strt_cnv) begin
      nchk++;
      if (exp_chq.size() == 0) begin
        nerr++;
        $display("FAIL strt_chnnl: unexpected strt_cnv on channel %0d", chnnl);
      end else begin
        ec = exp_chq.pop_front();
        if (chnnl !== ec) begin
          nerr++;
          $display("FAIL strt_chnnl: got %0d expected %0d", chnnl, ec);
        end
      end
    end
    if (rst_n && req_done) begin
      nchk++;
      if (exp_resq.size() == 0) begin
        nerr++;
        $display("FAIL req_res: unexpected req_done, req_res=%h", req_res);
      end else begin
        er = exp_resq.pop_front();
        if (req_res !== er) begin
          nerr++;
          $display("FAIL req_res: got %h expected %h", req_res, er);
        end
      end
    end
  end

  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      case (which)
        0: ok = strt_cnv;
        1: ok = scan_done;
        2: ok = cnv_err;
        3: ok = req_ack;
        default: ok = req_done;
      endcase
    end
  endtask

  task automatic apply_reset();
    en = 1'b0; req = 1'b0; hold0 = 1'b0;
    rst_n = 1'b0;
    exp_chq.delete(); exp_resq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    nchk++;
    if ({strt_cnv, req_ack, req_done, scan_done, cnv_err, busy} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctl: got %b expected 000000", {strt_cnv, req_ack, req_done, scan_done, cnv_err, busy});
    end
    nchk++;
    if (ch_data !== 96'h0 || ch_vld !== 8'h0) begin
      nerr++;
      $display("FAIL reset_regs: ch_data=%h ch_vld=%h expected 0", ch_data, ch_vld);
    end
    nchk++;
    if (req_res !== 12'h0 || chnnl !== 3'd0) begin
      nerr++;
      $display("FAIL reset_host: req_res=%h chnnl=%0d expected 0", req_res, chnnl);
    end
  endtask

  task automatic test_full_scan();
    bit ok;
    logic [11:0] ev;
    apply_reset();
    ch_mask = 8'hFF;
    for (int i = 0; i < 8; i++) exp_chq.push_back(3'(i));
    en = 1'b1;
    wait_for(0, 50, ok);
    en = 1'b0;
    wait_for(1, 1000, ok);
    nchk++;
    if (!ok) begin nerr++; $display("FAIL full_scan_done: timed out, scan_done=%b", scan_done); end
    for (int i = 0; i < 8; i++) begin
      ev = 12'(12'h100 + i);
      nchk++;
      if (ch_data[i*12 +: 12] !== ev) begin
        nerr++;
        $display("FAIL full_ch_data[%0d]: got %h expected %h", i, ch_data[i*12 +: 12], ev);
      end
    end
    nchk++;
    if (ch_vld !== 8'hFF) begin nerr++; $display("FAIL full_ch_vld: got %h expected ff", ch_vld); end
    nchk++;
    if (exp_chq.size() != 0) begin nerr++; $display("FAIL full_seq: %0d channels not started, expected 0", exp_chq.size()); end
  endtask

  task automatic test_sparse_gap();
    bit ok;
    int t_sd, t_s;
    apply_reset();
    ch_mask = 8'b1010_0100;
    for (int r = 0; r < 2; r++) begin
      exp_chq.push_back(3'd2); exp_chq.push_back(3'd5); exp_chq.push_back(3'd7);
    end
    en = 1'b1;
    wait_for(1, 1000, ok);
    t_sd = cyc;
    nchk++;
    if (!ok) begin nerr++; $display("FAIL sparse_done: timed out, scan_done=%b", scan_done); end
    nchk++;
    if (ch_vld !== 8'hA4) begin nerr++; $display("FAIL sparse_vld: got %h expected a4", ch_vld); end
    nchk++;
    if (ch_data[5*12 +: 12] !== 12'h105 || ch_data[0 +: 12] !== 12'h000) begin
      nerr++;
      $display("FAIL sparse_data: ch5=%h ch0=%h expected 105 000", ch_data[5*12 +: 12], ch_data[0 +: 12]);
    end
    wait_for(0, 200, ok);
    t_s = cyc;
    en = 1'b0;
    nchk++;
    if (!ok || (t_s - t_sd) < 18) begin
      nerr++;
      $display("FAIL sparse_gap: strt_cnv %0d cycles after scan_done (ok=%b) expected >= 18", t_s - t_sd, ok);
    end
    wait_for(1, 1000, ok);
    repeat (60) @(negedge clk);
    nchk++;
    if (!ok || exp_chq.size() != 0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL sparse_stop: ok=%b pending=%0d busy=%b expected 1 0 0", ok, exp_chq.size(), busy);
    end
  endtask

  task automatic test_host();
    bit ok, hit;
    apply_reset();
    ch_mask = 8'hFF;
    exp_chq.push_back(3'd0); exp_chq.push_back(3'd1); exp_chq.push_back(3'd3);
    for (int i = 2; i < 8; i++) exp_chq.push_back(3'(i));
    en = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      hit = strt_cnv && chnnl == 3'd1;
    end
    en = 1'b0;
    req_chnnl = 3'd3;
    req = 1'b1;
    exp_resq.push_back(12'h103);
    wait_for(3, 100, ok);
    nchk++;
    if (!hit || !ok || chnnl !== 3'd3) begin
      nerr++;
      $display("FAIL host_ack: hit=%b ack=%b chnnl=%0d expected 1 1 3", hit, ok, chnnl);
    end
    req = 1'b0;
    wait_for(4, 100, ok);
    nchk++;
    if (!ok || ch_vld[3] !== 1'b0 || ch_data[3*12 +: 12] !== 12'h000) begin
      nerr++;
      $display("FAIL host_iso: done=%b vld3=%b ch3=%h expected 1 0 000", ok, ch_vld[3], ch_data[3*12 +: 12]);
    end
    wait_for(1, 1000, ok);
    nchk++;
    if (!ok || ch_vld !== 8'hFF || ch_data[3*12 +: 12] !== 12'h103) begin
      nerr++;
      $display("FAIL host_resume: done=%b vld=%h ch3=%h expected 1 ff 103", ok, ch_vld, ch_data[3*12 +: 12]);
    end
    nchk++;
    if (exp_chq.size() != 0 || exp_resq.size() != 0) begin
      nerr++;
      $display("FAIL host_seq: pending ch=%0d res=%0d expected 0 0", exp_chq.size(), exp_resq.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0, t1;
    apply_reset();
    ch_mask = 8'b0000_0011;
    hold0 = 1'b1;
    exp_chq.push_back(3'd0); exp_chq.push_back(3'd1);
    en = 1'b1;
    wait_for(0, 50, ok);
    t0 = cyc;
    en = 1'b0;
    wait_for(2, 200, ok);
    t1 = cyc;
    nchk++;
    if (!ok || (t1 - t0) != 64) begin
      nerr++;
      $display("FAIL timeout_lat: cnv_err %0d cycles after strt_cnv (ok=%b) expected 64", t1 - t0, ok);
    end
    nchk++;
    if (ch_vld !== 8'h00) begin nerr++; $display("FAIL timeout_vld: got %h expected 00", ch_vld); end
    wait_for(1, 200, ok);
    nchk++;
    if (!ok || ch_vld !== 8'h02 || cnv_err !== 1'b1 || exp_chq.size() != 0) begin
      nerr++;
      $display("FAIL timeout_adv: done=%b vld=%h err=%b pending=%0d expected 1 02 1 0", ok, ch_vld, cnv_err, exp_chq.size());
    end
    hold0 = 1'b0;
  endtask

  task automatic test_invert();
    bit ok;
    apply_reset();
    ch_mask = 8'h01;
    adc_raw[0] = 12'hA5C;
    exp_chq.push_back(3'd0);
    en = 1'b1;
    wait_for(0, 50, ok);
    en = 1'b0;
    wait_for(1, 200, ok);
    nchk++;
    if (!ok || ch_data[11:0] !== 12'h5A3) begin
      nerr++;
      $display("FAIL invert_on: got %h expected 5a3 (done=%b)", ch_data[11:0], ok);
    end
    nchk++;
    if (ch_data0[11:0] !== 12'hA5C || ch_vld0 !== 8'h01) begin
      nerr++;
      $display("FAIL invert_off: got %h vld=%h expected a5c 01", ch_data0[11:0], ch_vld0);
    end
    adc_raw[0] = ~12'h100;
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    apply_reset();
    ch_mask = 8'hFF;
    exp_chq.push_back(3'd0); exp_chq.push_back(3'd1); exp_chq.push_back(3'd2);
    en = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      hit = strt_cnv && chnnl == 3'd2;
    end
    repeat (2) @(negedge clk);
    nchk++;
    if (!hit || busy !== 1'b1) begin nerr++; $display("FAIL midrst_pre: hit=%b busy=%b expected 1 1", hit, busy); end
    #1 rst_n = 1'b0;
    #1;
    nchk++;
    if ({busy, strt_cnv, scan_done, cnv_err} !== 4'b0 || chnnl !== 3'd0 || ch_vld !== 8'h0 || ch_data !== 96'h0) begin
      nerr++;
      $display("FAIL midrst_async: busy=%b chnnl=%0d vld=%h data=%h expected all 0", busy, chnnl, ch_vld, ch_data);
    end
    exp_chq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_chq.push_back(3'(i));
    wait_for(0, 50, ok);
    en = 1'b0;
    wait_for(1, 1000, ok);
    nchk++;
    if (!ok || ch_vld !== 8'hFF || exp_chq.size() != 0) begin
      nerr++;
      $display("FAIL midrst_restart: done=%b vld=%h pending=%0d expected 1 ff 0", ok, ch_vld, exp_chq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) adc_raw[i] = ~(12'(12'h100 + i));
    test_reset();
    test_full_scan();
    test_sparse_gap();
    test_host();
    test_timeout();
    test_invert();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/a2d_scan_ctrl.md
Name: a2d_scan_ctrl

Overview:
Sequencer in front of A2D_intf. It round-robins conversions over the enabled ADC128S channels and keeps a per-channel result register file for the rest of the design. It also serves single-shot conversion requests from a host port, and these requests take priority over the next scan slot. It owns strt_cnv/chnnl and consumes cnv_cmplt/res. It never touches the SPI pins.

Parameters:
SCAN_GAP, 1024, idle cycles between the end of one full scan and the start of the next (0 = back-to-back).
CNV_TIMEOUT, 4096, cycles allowed from strt_cnv to cnv_cmplt before the conversion is aborted.
INVERT_RES, 1, 1 = store ~res (the ADC128S path returns complemented data); 0 = store res.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; sampled only in IDLE
ch_mask  in  8  scan channel enables; bit i = channel i
strt_cnv  out  1  one-cycle start pulse to A2D_intf
chnnl  out  3  channel to A2D_intf; stable from strt_cnv until completion or timeout
cnv_cmplt  in  1  A2D_intf completion; level, cleared by A2D_intf on strt_cnv
res  in  12  A2D_intf result; valid while cnv_cmplt=1
req  in  1  host single-shot request (level, held until req_ack)
req_chnnl  in  3  host channel; must be stable while req=1
req_ack  out  1  one-cycle pulse, same cycle as the strt_cnv that serves the request
req_done  out  1  one-cycle pulse when req_res is updated
req_res  out  12  last host result (INVERT_RES applied)
ch_data  out  96  channel i result at [12i+11:12i]
ch_vld  out  8  bit i set on first good conversion of channel i
scan_done  out  1  one-cycle pulse after the last enabled channel of a scan completes
cnv_err  out  1  sticky; set on timeout; cleared only by reset
busy  out  1  high in any state other than IDLE and GAP

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including ch_data, ch_vld, req_res and cnv_err. Scan pointer=0, gap and timeout counters=0.
- States: IDLE, PICK, START, CONV, GAP.
- IDLE -> PICK when req=1, or when en=1 and ch_mask!=0.
- PICK (1 cycle), host request has priority:
  - if req=1: target=req_chnnl, src=HOST.
  - else: target = lowest enabled channel >= scan pointer, src=SCAN.
  - chnnl is registered with the target. Then -> START.
- START (1 cycle): strt_cnv=1; req_ack=1 if src=HOST; timeout counter cleared. Then -> CONV.
- CONV:
  - cnv_cmplt is ignored on the first CONV cycle (blanking for the stale level).
  - After blanking, cnv_cmplt=1 -> capture and route the result:
    - HOST: req_res updated, req_done pulses. Scan pointer is unchanged.
    - SCAN: ch_data[target] updated, ch_vld[target] set. Scan pointer = target+1.
  - Timeout counter reaching CNV_TIMEOUT-1 -> cnv_err=1. No data or vld update, no req_done. A SCAN slot still advances the pointer.
  - Next state after completion or timeout:
    - a SCAN slot that was the last enabled channel: scan_done pulses, pointer returns to 0, -> GAP.
    - otherwise, if req=1 or more scan channels remain: -> PICK.
    - otherwise: -> IDLE.
- GAP: counts SCAN_GAP cycles, then -> IDLE. A req=1 during GAP -> PICK immediately; the gap count is frozen and resumes afterwards. SCAN_GAP=0 goes straight to IDLE.
- Host requests are served between scan slots and never abort a conversion in progress.
- Consecutive strt_cnv pulses are at least 3 cycles apart.
- ch_mask changing mid-scan takes effect at the next PICK. If no enabled channels remain above the pointer, treat the scan as complete: scan_done, -> GAP.
- en=0 mid-scan: the current scan finishes, then the block stays in IDLE.
- Simultaneous timeout and cnv_cmplt on the same cycle: cnv_cmplt wins.
- Result is 12 bits; INVERT_RES is a bitwise NOT with no sign or width change.

Decomposition:
- Shared package a2d_pkg holds:
  - state enum
  - src enum {SCAN, HOST}
  - NUM_CH=8, RES_W=12
- One natural sub-module: a2d_next_ch, a combinational find-next-set-bit (mask, pointer) -> (ch, found) used by PICK.
- Register file and FSM stay in the top level.

Test Plan:
- ch_mask=8'hFF, en=1, ADC model loaded with channel i = 12'h100+i: after the first scan_done, ch_data holds 12'h100..12'h107, ch_vld=8'hFF, and chnnl sequenced 0..7.
- ch_mask=8'b1010_0100: strt_cnv only for channels 2, 5, 7; ch_vld=8'hA4; scan_done follows channel 7; with SCAN_GAP=16, next strt_cnv >= 16+2 cycles after scan_done.
- req=1, req_chnnl=3 raised during the channel 1 conversion: channel 1 completes, then the host slot runs (req_ack with chnnl=3, req_done, req_res=12'h103, ch_data[3] unchanged), then the scan resumes at channel 2.
- ADC model holds cnv_cmplt low, CNV_TIMEOUT=64: cnv_err=1 exactly 64 cycles after strt_cnv, ch_vld bit not set, scan advances to the next channel.
- INVERT_RES=0, res=12'hA5C: stored value 12'hA5C; INVERT_RES=1: stored value 12'h5A3.
- rst_n low mid-CONV: all outputs 0 asynchronously; after release with en=1, the scan restarts at channel 0.
